// File: rtl/ntsc_dsm_dac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntsc_dsm_pkg : shared constants and helpers for the NTSC DSM DAC     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package ntsc_dsm_pkg;

    localparam logic [15:0] c_LFSR_DEFAULT_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5
    localparam logic [15:0] c_LFSR_TAP_MASK     = 16'h002D;

    function automatic logic [15:0] lfsr_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? c_LFSR_DEFAULT_SEED : seed;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int saturate(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit order_ok(input int order);
        return (order == 1) || (order == 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntsc_dsm_dac_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntsc_dsm_dac_if : sample/capture inputs and DAC outputs of the DSM   |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
interface ntsc_dsm_dac_if #(
    parameter int C_CH    = 1,
    parameter int C_IN_W  = 6,
    parameter int C_OUT_W = 1
);
    logic                      PX_CK_EE_i;
    logic                      EN_i;
    logic                      CLR_i;
    logic [C_CH*C_IN_W-1:0]    VIDEOs_i;
    logic [C_CH*C_OUT_W-1:0]   DACs_o;
    logic [C_CH-1:0]           OVF_o;

    modport master (
        output PX_CK_EE_i, EN_i, CLR_i, VIDEOs_i,
        input  DACs_o, OVF_o
    );

    modport slave (
        input  PX_CK_EE_i, EN_i, CLR_i, VIDEOs_i,
        output DACs_o, OVF_o
    );
endinterface
`default_nettype wire

// File: rtl/ntsc_dsm_dac_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntsc_dsm_ch : one channel - hold register, 1st/2nd order modulator   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ntsc_dsm_ch
    import ntsc_dsm_pkg::*;
#(
    parameter int C_IN_W  = 6,
    parameter int C_OUT_W = 1,
    parameter int C_ORDER = 1
) (
    input  wire logic                ck_i,
    input  wire logic                rst_i,
    input  wire logic                px_ck_ee_i,
    input  wire logic                en_i,
    input  wire logic                clr_i,
    input  wire logic                dither_i,
    input  wire logic [C_IN_W-1:0]   video_i,
    output logic      [C_OUT_W-1:0]  dac_o,
    output logic                     ovf_o
);
    localparam int c_E    = C_IN_W - C_OUT_W + 1;
    localparam int c_VW   = C_IN_W + 4;
    localparam int c_QMAX = (1 << C_OUT_W) - 1;
    localparam int c_EMAX = (1 << (c_E + 1)) - 1;
    localparam int c_EMIN = -(1 << (c_E + 1));

    logic        [C_IN_W-1:0]  hold_q, hold_d;
    logic signed [c_E+1:0]     e1_q, e1_d, e2_q, e2_d;
    logic        [C_OUT_W-1:0] dac_q, dac_d;
    logic                      ovf_q, ovf_d;

    logic signed [c_VW-1:0]    w_e1x, w_e2x, w_fb, w_v, w_qraw, w_q, w_e, w_es;
    logic                      w_hit;

    always_comb begin
        w_e1x  = {{(c_VW-c_E-2){e1_q[c_E+1]}}, e1_q};
        w_e2x  = {{(c_VW-c_E-2){e2_q[c_E+1]}}, e2_q};
        // Order 1 keeps its non-negative residue in e1 only
        w_fb   = (C_ORDER == 2) ? ((w_e1x <<< 1) - w_e2x) : w_e1x;
        w_v    = $signed({4'b0000, hold_q}) + w_fb + $signed({{(c_VW-1){1'b0}}, dither_i});
        w_qraw = w_v >>> c_E;
        w_q    = c_VW'(clamp(int'(w_qraw), 0, c_QMAX));
        w_e    = w_v - (w_q <<< c_E);
        w_es   = c_VW'(saturate(int'(w_e), c_EMIN, c_EMAX));
        w_hit  = (C_ORDER == 2) && en_i && ((w_q != w_qraw) || (w_es != w_e));

        hold_d = px_ck_ee_i ? video_i : hold_q;
        dac_d  = en_i ? w_q[C_OUT_W-1:0] : '0;
        e1_d   = en_i ? w_es[c_E+1:0] : '0;
        e2_d   = (en_i && (C_ORDER == 2)) ? e1_q : '0;
        ovf_d  = w_hit ? 1'b1 : (clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            hold_q <= '0;
            e1_q   <= '0;
            e2_q   <= '0;
            dac_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            e1_q   <= e1_d;
            e2_q   <= e2_d;
            dac_q  <= dac_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dac_o = dac_q;
    assign ovf_o = ovf_q;
endmodule
`default_nettype wire

// File: rtl/ntsc_dsm_dac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntsc_dsm_dac : multi-channel delta-sigma DAC stage, shared LFSR      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module ntsc_dsm_dac
    import ntsc_dsm_pkg::*;
#(
    parameter int          C_CH        = 1,
    parameter int          C_IN_W      = 6,
    parameter int          C_OUT_W     = 1,
    parameter int          C_ORDER     = 1,
    parameter int          C_DITHER    = 0,
    parameter logic [15:0] C_LFSR_SEED = 16'hACE1
) (
    input  wire logic      CK_i,
    input  wire logic      RST_i,
    ntsc_dsm_dac_if.slave  bus_if
);
    logic [15:0] lfsr_q, lfsr_d;

    if (!order_ok(C_ORDER)) begin : g_bad_order
        $error("ntsc_dsm_dac: C_ORDER must be 1 or 2");
    end

    always_comb lfsr_d = {^(lfsr_q & c_LFSR_TAP_MASK), lfsr_q[15:1]};

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            lfsr_q <= lfsr_seed(C_LFSR_SEED);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    for (genvar c = 0; c < C_CH; c++) begin : g_ch
        logic w_dither;
        assign w_dither = (C_DITHER != 0) ? lfsr_q[c % 16] : 1'b0;

        ntsc_dsm_ch #(
            .C_IN_W  (C_IN_W),
            .C_OUT_W (C_OUT_W),
            .C_ORDER (C_ORDER)
        ) u_ch (
            .ck_i       (CK_i),
            .rst_i      (RST_i),
            .px_ck_ee_i (bus_if.PX_CK_EE_i),
            .en_i       (bus_if.EN_i),
            .clr_i      (bus_if.CLR_i),
            .dither_i   (w_dither),
            .video_i    (bus_if.VIDEOs_i[c*C_IN_W +: C_IN_W]),
            .dac_o      (bus_if.DACs_o[c*C_OUT_W +: C_OUT_W]),
            .ovf_o      (bus_if.OVF_o[c])
        );
    end
endmodule
`default_nettype wire

// File: tb/tb_ntsc_dsm_dac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ntsc_dsm_dac : three DSM configurations against a reference model |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_ntsc_dsm_dac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        pxe = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] video = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: order 1, 1-bit  B: order 1, 3-bit  C: order 2, 1-bit, dithered
    ntsc_dsm_dac_if #(.C_CH(2), .C_IN_W(6), .C_OUT_W(1)) if_a ();
    ntsc_dsm_dac_if #(.C_CH(2), .C_IN_W(6), .C_OUT_W(3)) if_b ();
    ntsc_dsm_dac_if #(.C_CH(2), .C_IN_W(6), .C_OUT_W(1)) if_c ();

    assign if_a.PX_CK_EE_i = pxe;  assign if_a.EN_i = en;  assign if_a.CLR_i = clr;  assign if_a.VIDEOs_i = video;
    assign if_b.PX_CK_EE_i = pxe;  assign if_b.EN_i = en;  assign if_b.CLR_i = clr;  assign if_b.VIDEOs_i = video;
    assign if_c.PX_CK_EE_i = pxe;  assign if_c.EN_i = en;  assign if_c.CLR_i = clr;  assign if_c.VIDEOs_i = video;

    ntsc_dsm_dac #(.C_CH(2), .C_IN_W(6), .C_OUT_W(1), .C_ORDER(1), .C_DITHER(0), .C_LFSR_SEED(16'hACE1))
        u_a (.CK_i(clk), .RST_i(rst), .bus_if(if_a));
    ntsc_dsm_dac #(.C_CH(2), .C_IN_W(6), .C_OUT_W(3), .C_ORDER(1), .C_DITHER(0), .C_LFSR_SEED(16'hACE1))
        u_b (.CK_i(clk), .RST_i(rst), .bus_if(if_b));
    ntsc_dsm_dac #(.C_CH(2), .C_IN_W(6), .C_OUT_W(1), .C_ORDER(2), .C_DITHER(1), .C_LFSR_SEED(16'hACE1))
        u_c (.CK_i(clk), .RST_i(rst), .bus_if(if_c));

    localparam int OW  [3] = '{1, 3, 1};
    localparam int ORD [3] = '{1, 1, 2};
    localparam int DI  [3] = '{0, 0, 1};

    int m_hold [3][2];
    int m_e1   [3][2];
    int m_e2   [3][2];
    int m_ovf  [3][2];
    int m_lfsr = 16'hACE1;

    // Expected entry per DUT k: bits k*8+c*3 +:3 = output of channel c, k*8+6+c = flag of channel c
    logic [23:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [23:0] ent;
        int fb;
        ent = '0;
        for (int k = 0; k < 3; k++) begin
            int S, qmax;
            S    = 1 << (7 - OW[k]);
            qmax = (1 << OW[k]) - 1;
            for (int c = 0; c < 2; c++) begin
                int dac, d, v, qr, q, e, es;
                bit hit;
                dac = 0;
                hit = 1'b0;
                if (rst) begin
                    m_hold[k][c] = 0; m_e1[k][c] = 0; m_e2[k][c] = 0; m_ovf[k][c] = 0;
                end else begin
                    d = (DI[k] != 0) ? ((m_lfsr >> c) & 1) : 0;
                    if (!en) begin
                        m_e1[k][c] = 0; m_e2[k][c] = 0;
                    end else if (ORD[k] == 1) begin
                        v   = m_hold[k][c] + m_e1[k][c] + d;
                        dac = v / S;
                        m_e1[k][c] = v % S;
                    end else begin
                        v  = m_hold[k][c] + 2 * m_e1[k][c] - m_e2[k][c] + d;
                        qr = (v >= 0) ? (v / S) : -((-v + S - 1) / S);
                        q  = (qr < 0) ? 0 : ((qr > qmax) ? qmax : qr);
                        e  = v - q * S;
                        es = (e < -2 * S) ? -2 * S : ((e > 2 * S - 1) ? 2 * S - 1 : e);
                        hit = (q != qr) || (es != e);
                        dac = q;
                        m_e2[k][c] = m_e1[k][c];
                        m_e1[k][c] = es;
                    end
                    if (hit)      m_ovf[k][c] = 1;
                    else if (clr) m_ovf[k][c] = 0;
                    if (pxe) m_hold[k][c] = int'(video[c*6 +: 6]);
                end
                ent[k*8 + c*3 +: 3] = dac[2:0];
                ent[k*8 + 6 + c]    = m_ovf[k][c][0];
            end
        end
        if (rst) begin
            m_lfsr = 16'hACE1;
        end else begin
            fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
            m_lfsr = (m_lfsr >> 1) | (fb << 15);
        end
        exp_q.push_back(ent);
    endtask

    task automatic cycle(input logic r, input logic e, input logic p, input logic cl, input logic [11:0] v);
        @(negedge clk);
        rst = r; en = e; pxe = p; clr = cl; video = v;
        model_step();
        @(posedge clk);
    endtask

    // Counts outputs over n cycles with capture disabled and junk on the sample bus
    task automatic count_ones(input int n, output int sa0, output int sa1, output int sb0, output int sb1);
        sa0 = 0; sa1 = 0; sb0 = 0; sb1 = 0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'($urandom));
            #1;
            sa0 += int'(if_a.DACs_o[0]);
            sa1 += int'(if_a.DACs_o[1]);
            sb0 += int'(if_b.DACs_o[2:0]);
            sb1 += int'(if_b.DACs_o[5:3]);
        end
    endtask

    always @(posedge clk) begin
        logic [23:0] ent, act;
        #1;
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            act = '0;
            act[0 +: 3]  = {2'b00, if_a.DACs_o[0]};
            act[3 +: 3]  = {2'b00, if_a.DACs_o[1]};
            act[6 +: 2]  = if_a.OVF_o;
            act[8 +: 3]  = if_b.DACs_o[2:0];
            act[11 +: 3] = if_b.DACs_o[5:3];
            act[14 +: 2] = if_b.OVF_o;
            act[16 +: 3] = {2'b00, if_c.DACs_o[0]};
            act[19 +: 3] = {2'b00, if_c.DACs_o[1]};
            act[22 +: 2] = if_c.OVF_o;
            check("sb_order1_1bit", int'(act[7:0]),   int'(ent[7:0]));
            check("sb_order1_3bit", int'(act[15:8]),  int'(ent[15:8]));
            check("sb_order2_dith", int'(act[23:16]), int'(ent[23:16]));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sa0, sa1, sb0, sb1;

        cycle(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        #1;
        check("reset_dac_a", int'(if_a.DACs_o), 0);
        check("reset_ovf_c", int'(if_c.OVF_o), 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);

        // ch0 = 32 (mid-scale), ch1 = 63 (full-scale); later bus changes are ignored
        cycle(1'b0, 1'b1, 1'b1, 1'b0, {6'd63, 6'd32});
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'($urandom));
        count_ones(64, sa0, sa1, sb0, sb1);
        check("mid_scale_ones",  sa0, 32);
        check("full_scale_ones", sa1, 63);
        check("multibit_x32",    sb0, 128);
        check("multibit_x63",    sb1, 252);
        check("order1_no_ovf",   int'(if_a.OVF_o), 0);

        // ch0 = 0, ch1 = 20: zero input and the 1,1,1,2 multibit pattern
        cycle(1'b0, 1'b1, 1'b1, 1'b0, {6'd20, 6'd0});
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'($urandom));
        count_ones(64, sa0, sa1, sb0, sb1);
        check("zero_scale_ones", sa0, 0);
        check("multibit_x20",    sb1, 80);

        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 100) == 0, ($urandom % 10) != 0, ($urandom % 4) == 0,
                  ($urandom % 20) == 0, 12'($urandom));
        end

        // Order 2 clamp at full scale sets the sticky flag; only a clear drops it
        cycle(1'b0, 1'b1, 1'b1, 1'b0, {6'd63, 6'd63});
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, {6'd63, 6'd63});
        #1;
        check("ovf_set",      int'(if_c.OVF_o[0]), 1);
        check("ovf_order1_0", int'(if_a.OVF_o), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, {6'd63, 6'd63});
        #1;
        check("ovf_sticky",   int'(if_c.OVF_o[0]), 1);
        check("en_low_dac",   int'(if_c.DACs_o), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, {6'd63, 6'd63});
        #1;
        check("ovf_cleared",  int'(if_c.OVF_o[0]), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, {6'd63, 6'd63});

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ntsc_dsm_dac.md
# ntsc_dsm_dac

Parametrised multi-channel delta-sigma output stage for the NTSC square-pixel video path. It replaces the fixed 6-bit-in / 1-bit-out first-order modulator at the end of the composite encoder. Input width, output width, channel count, modulator order (1 or 2) and optional LFSR dither are all selectable. Samples are captured on the pixel clock enable, and the modulator runs every master clock.

## Interface
- C_CH, 1, number of independent channels
- C_IN_W, 6, unsigned input sample width per channel (≥2)
- C_OUT_W, 1, DAC output width per channel (1..C_IN_W-1)
- C_ORDER, 1, modulator order: 1 or 2; any other value is a compile-time error
- C_DITHER, 0, 1 = add one LFSR bit to each modulator sum
- C_LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1
- CK_i  in  1  master clock, n × 12.27272 MHz
- RST_i  in  1  synchronous, active-high reset
- PX_CK_EE_i  in  1  pixel clock enable; samples are captured when high
- EN_i  in  1  modulator enable
- CLR_i  in  1  synchronous clear of the sticky OVF_o flags
- VIDEOs_i  in  C_CH×C_IN_W  input samples; channel c occupies [c×C_IN_W +: C_IN_W]
- DACs_o  out  C_CH×C_OUT_W  registered modulator outputs, same packing
- OVF_o  out  C_CH  sticky per-channel clamp flag (order 2 only; tied to 0 for order 1)

## Operation
- E = C_IN_W − C_OUT_W + 1 is the number of fraction bits. Mean output = x / 2^E.
- **Hold register:** HOLD[c] ← VIDEOs_i[c] on a cycle with PX_CK_EE_i = 1; otherwise it keeps its value.
- **Order 1:**
  - e is E bits unsigned.
  - s = HOLD + e + d, width C_IN_W+1.
  - DACs_o ← s[C_IN_W:E] and e ← s[E−1:0].
  - No overflow is possible, so OVF_o = 0.
  - With C_OUT_W = 1 this is bit-identical to the existing 7-bit DSs modulator.
- **Order 2 (error-feedback form):**
  - e1 and e2 are signed, width E+2.
  - v = HOLD + 2·e1 − e2 + d, signed, width C_IN_W+4.
  - q = clamp(v >>> E, 0, 2^C_OUT_W − 1).
  - e = v − (q << E), saturated to [−2^(E+1), 2^(E+1)−1]; then e2 ← e1, e1 ← e.
  - DACs_o ← q.
  - OVF_o[c] ← 1 when either the q clamp or the e saturation is active.
- **Dither:** d = LFSR[c mod 16] when C_DITHER = 1, else 0.
  - One shared 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting every CK_i cycle.
- **EN_i = 0:** DACs_o ← 0 and all error states ← 0. HOLD and the LFSR keep running.
- **OVF_o** clears only on RST_i or CLR_i. If CLR_i and a new overflow occur in the same cycle, the flag is set.
- **RST_i (any cycle, including mid-sample):** DACs_o, OVF_o, HOLD and all error states ← 0; LFSR ← seed. RST_i has priority over EN_i, CLR_i and PX_CK_EE_i.

## Timing
- Reset values: DACs_o = 0, OVF_o = 0.
- Latency: VIDEOs_i sampled at edge N (PX_CK_EE_i high) → HOLD valid after edge N → first DACs_o depending on it appears after edge N+1 (2 cycles).
- The modulator updates every CK_i cycle regardless of PX_CK_EE_i. The output density within one pixel period is therefore determined by the CK_i/pixel ratio.
- EN_i rising: the first nonzero output can appear after the following edge; the error states start from 0.
- No combinational path exists from any input to any output.

## Structure
- Package ntsc_dsm_pkg holds:
  - LFSR default seed and tap mask
  - clamp and saturate functions
  - the C_ORDER legality check
- Sub-module ntsc_dsm_ch implements one channel: HOLD, error states, quantiser and OVF flag. The top instantiates it C_CH times in a generate loop and owns the shared LFSR.
- Expected size: roughly 150–250 lines of RTL in total.

## Test plan
1. **Mid-scale order 1:** order 1, C_IN_W 6, C_OUT_W 1, x = 32 held → after 2-cycle latency DACs_o alternates 1,0 and has exactly 32 ones in any 64-cycle window.
2. **Full-scale extremes:** x = 0 → DACs_o is always 0. x = 63 → exactly 63 ones per 64 cycles, and OVF_o stays 0.
3. **Multibit order 1:** C_OUT_W 3 (E = 4), x = 20 → repeating pattern 1,1,1,2 (sum 5 per 4 cycles).
4. **Capture gating:** change VIDEOs_i while PX_CK_EE_i = 0 → DACs_o sequence is unchanged until the next PX_CK_EE_i pulse, then reflects the new value 2 cycles later.
5. **Order 2 step response:** order 2, C_OUT_W 1, step x 0 → 48 → over 1024 cycles after the step, count of ones = 768 ± 2. Force a clamp with C_OUT_W 1, x = 63 and dither on → OVF_o rises; it stays high until a CLR_i pulse, then returns to 0.
6. **Reset and enable mid-operation:**
   - Assert RST_i for one cycle during scenario 1 → the next cycle gives DACs_o = 0, and the sequence then replays identically to a fresh start.
   - EN_i low → DACs_o = 0 on the following cycle.
   - C_CH 2 with different inputs per channel → the channels are independent.
